// File: rtl/ifetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues single outstanding reads
// to instruction memory and queues {pc, instruction} pairs toward decode.
module ifetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Redirect,
   input  logic [31:0] Redirect_pc,
   output logic        Mem_ren,
   output logic [31:0] Mem_addr,
   input  logic        Mem_stall,
   input  logic [31:0] Mem_rdata,
   output logic        Inst_valid,
   output logic [31:0] Inst,
   output logic [31:0] Inst_pc,
   input  logic        Inst_ready
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
   localparam logic [AW-1:0] IDX_ONE   = AW'(1);
   localparam logic [AW-1:0] IDX_ZERO  = AW'(0);

   typedef enum logic [0:0] {
      FETCH = 1'b0,
      DROP  = 1'b1
   } state_t;

   state_t        state_r, state_nxt_s;
   logic [31:0]   fpc_r, fpc_nxt_s;
   logic          ren_r, ren_nxt_s;
   logic [31:0]   addr_r, addr_nxt_s;
   logic [CW-1:0] count_r, count_nxt_s;
   logic [AW-1:0] head_r, head_nxt_s, wr_idx_s;
   logic [31:0]   fifo_inst_r [DEPTH];
   logic [31:0]   fifo_pc_r   [DEPTH];
   logic [31:0]   inst_r, inst_nxt_s;
   logic [31:0]   inst_pc_r, inst_pc_nxt_s;
   logic [31:0]   redirect_target_s;
   logic          complete_s, push_s, pop_s;
   logic          rpc_unused_s;

   assign complete_s        = ren_r & ~Mem_stall;
   assign pop_s             = (count_r != CNT_ZERO) & Inst_ready;
   assign wr_idx_s          = head_r + count_r[AW-1:0];
   assign redirect_target_s = {Redirect_pc[31:2], 2'b00};
   assign rpc_unused_s      = ^Redirect_pc[1:0];

   assign Mem_ren    = ren_r;
   assign Mem_addr   = addr_r;
   assign Inst_valid = (count_r != CNT_ZERO);
   assign Inst       = inst_r;
   assign Inst_pc    = inst_pc_r;

   // Fetch state machine: next state, next fetch PC and push decision.
   always_comb begin
      state_nxt_s = state_r;
      fpc_nxt_s   = fpc_r;
      push_s      = 1'b0;
      case (state_r)
         FETCH: begin
            if (Redirect) begin
               fpc_nxt_s = redirect_target_s;
               // A stalled request cannot be withdrawn; its data is dropped later.
               if (ren_r && Mem_stall) begin
                  state_nxt_s = DROP;
               end else begin
                  state_nxt_s = FETCH;
               end
            end else if (complete_s) begin
               push_s    = 1'b1;
               fpc_nxt_s = fpc_r + 32'd4;
            end else begin
               fpc_nxt_s = fpc_r;
            end
         end
         DROP: begin
            if (Redirect) begin
               fpc_nxt_s = redirect_target_s;
            end else begin
               fpc_nxt_s = fpc_r;
            end
            if (complete_s) begin
               state_nxt_s = FETCH;
            end else begin
               state_nxt_s = DROP;
            end
         end
         default: begin
            state_nxt_s = FETCH;
         end
      endcase
   end

   // FIFO occupancy and head pointer; a redirect flushes everything.
   always_comb begin
      count_nxt_s = count_r;
      head_nxt_s  = head_r;
      if (Redirect) begin
         count_nxt_s = CNT_ZERO;
         head_nxt_s  = IDX_ZERO;
      end else begin
         case ({push_s, pop_s})
            2'b10: begin
               count_nxt_s = count_r + CNT_ONE;
            end
            2'b01: begin
               count_nxt_s = count_r - CNT_ONE;
               head_nxt_s  = head_r + IDX_ONE;
            end
            2'b11: begin
               head_nxt_s = head_r + IDX_ONE;
            end
            default: begin
               count_nxt_s = count_r;
            end
         endcase
      end
   end

   // Next memory request; DROP keeps presenting the abandoned address until it completes.
   always_comb begin
      ren_nxt_s  = 1'b0;
      addr_nxt_s = {fpc_nxt_s[31:2], 2'b00};
      if (state_nxt_s == DROP) begin
         ren_nxt_s  = 1'b1;
         addr_nxt_s = addr_r;
      end else begin
         ren_nxt_s  = (count_nxt_s < DEPTH_C);
         addr_nxt_s = {fpc_nxt_s[31:2], 2'b00};
      end
   end

   // Next head-of-queue output; bypass when the pushed entry becomes the head.
   always_comb begin
      inst_nxt_s    = inst_r;
      inst_pc_nxt_s = inst_pc_r;
      if (!Redirect && (count_nxt_s != CNT_ZERO)) begin
         if (push_s && (wr_idx_s == head_nxt_s)) begin
            inst_nxt_s    = Mem_rdata;
            inst_pc_nxt_s = fpc_r;
         end else begin
            inst_nxt_s    = fifo_inst_r[head_nxt_s];
            inst_pc_nxt_s = fifo_pc_r[head_nxt_s];
         end
      end else begin
         inst_nxt_s    = inst_r;
         inst_pc_nxt_s = inst_pc_r;
      end
   end

   // Control and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= FETCH;
         fpc_r     <= RESET_PC;
         ren_r     <= 1'b0;
         addr_r    <= {RESET_PC[31:2], 2'b00};
         count_r   <= CNT_ZERO;
         head_r    <= IDX_ZERO;
         inst_r    <= 32'h0000_0000;
         inst_pc_r <= 32'h0000_0000;
      end else begin
         state_r   <= state_nxt_s;
         fpc_r     <= fpc_nxt_s;
         ren_r     <= ren_nxt_s;
         addr_r    <= addr_nxt_s;
         count_r   <= count_nxt_s;
         head_r    <= head_nxt_s;
         inst_r    <= inst_nxt_s;
         inst_pc_r <= inst_pc_nxt_s;
      end
   end

   // FIFO storage.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_inst_r[i] <= 32'h0000_0000;
            fifo_pc_r[i]   <= 32'h0000_0000;
         end
      end else if (push_s) begin
         fifo_inst_r[wr_idx_s] <= Mem_rdata;
         fifo_pc_r[wr_idx_s]   <= fpc_r;
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// Table-driven cycle checks of ifetch_unit plus a scoreboard of expected {pc, inst} pairs.
module tb_ifetch_unit;

   logic        clk;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        mem_ren;
   logic [31:0] mem_addr;
   logic        mem_stall;
   logic [31:0] mem_rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;

   typedef struct {
      logic        rst;
      logic        redir;
      logic [31:0] rpc;
      logic        stall;
      logic        ready;
      logic        e_ren;
      logic [31:0] e_addr;
      logic        e_valid;
      logic        push;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } sb_t;

   vec_t tv[$];
   sb_t  sbq[$];
   int   checks = 0;
   int   errors = 0;
   int   row_i  = -1;

   ifetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .Redirect   (redirect),
      .Redirect_pc(redirect_pc),
      .Mem_ren    (mem_ren),
      .Mem_addr   (mem_addr),
      .Mem_stall  (mem_stall),
      .Mem_rdata  (mem_rdata),
      .Inst_valid (inst_valid),
      .Inst       (inst),
      .Inst_pc    (inst_pc),
      .Inst_ready (inst_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] word_f(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   // Instruction memory model: data is a fixed function of the address.
   assign mem_rdata = word_f(mem_addr);

   function automatic vec_t v(input logic r, input logic rd, input logic [31:0] rpc,
                              input logic st, input logic rdy, input logic ren,
                              input logic [31:0] addr, input logic vld, input logic psh);
      vec_t t;
      t.rst = r; t.redir = rd; t.rpc = rpc; t.stall = st; t.ready = rdy;
      t.e_ren = ren; t.e_addr = addr; t.e_valid = vld; t.push = psh;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %h, expected %h", name, row_i, act, exp);
      end
   endtask

   initial begin
      sb_t e;
      rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; mem_stall = 1'b0; inst_ready = 1'b0;

      //    rst   redir rpc            stall ready ren   addr           valid push
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0)); // 0
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b1));
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_0004, 1'b1, 1'b1));
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 1'b1));
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_000C, 1'b1, 1'b1));
      tv.push_back(v(1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_0010, 1'b1, 1'b0)); // 5
      tv.push_back(v(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0));
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0));
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b1));
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0000_0004, 1'b1, 1'b1));
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0008, 1'b1, 1'b0)); // 10
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0008, 1'b1, 1'b0));
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0000_0008, 1'b1, 1'b0));
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 1'b0));
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0000_0008, 1'b0, 1'b0));
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0000_0008, 1'b0, 1'b0)); // 15
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_0008, 1'b0, 1'b1));
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0000_000C, 1'b1, 1'b0));
      tv.push_back(v(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b0, 1'b1, 32'h0000_000C, 1'b1, 1'b0));
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0000_000C, 1'b0, 1'b0));
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0000_000C, 1'b0, 1'b0)); // 20
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b0, 1'b1));
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_0204, 1'b1, 1'b1));
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0000_0208, 1'b1, 1'b1));
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_020C, 1'b1, 1'b0));
      tv.push_back(v(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 32'h0000_020C, 1'b1, 1'b0)); // 25
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b1));
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_0104, 1'b1, 1'b1));
      tv.push_back(v(1'b0, 1'b1, 32'h0000_0106, 1'b0, 1'b1, 1'b1, 32'h0000_0108, 1'b1, 1'b0));
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_0104, 1'b0, 1'b1));
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_0108, 1'b1, 1'b1)); // 30
      tv.push_back(v(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 32'h0000_010C, 1'b1, 1'b0));
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1));
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b1));
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0000_0004, 1'b1, 1'b0));
      tv.push_back(v(1'b0, 1'b1, 32'h0000_0300, 1'b1, 1'b1, 1'b1, 32'h0000_0004, 1'b0, 1'b0)); // 35
      tv.push_back(v(1'b0, 1'b1, 32'h0000_0400, 1'b1, 1'b1, 1'b1, 32'h0000_0004, 1'b0, 1'b0));
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_0004, 1'b0, 1'b0));
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_0400, 1'b0, 1'b1));
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_0404, 1'b1, 1'b1));
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0000_0408, 1'b1, 1'b0)); // 40
      tv.push_back(v(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0000_0408, 1'b0, 1'b0));
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0));
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b1));
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_0004, 1'b1, 1'b1));
      tv.push_back(v(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0000_0008, 1'b1, 1'b1)); // 45

      // Outputs while reset is held.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_ren",   {31'h0, mem_ren},    32'h0000_0000);
      chk("reset_addr",  mem_addr,            32'h0000_0000);
      chk("reset_valid", {31'h0, inst_valid}, 32'h0000_0000);
      chk("reset_inst",  inst,                32'h0000_0000);
      chk("reset_pc",    inst_pc,             32'h0000_0000);

      for (int i = 0; i < tv.size(); i++) begin
         @(posedge clk);
         #1;
         row_i       = i;
         rst         = tv[i].rst;
         redirect    = tv[i].redir;
         redirect_pc = tv[i].rpc;
         mem_stall   = tv[i].stall;
         inst_ready  = tv[i].ready;
         @(negedge clk);
         chk("mem_ren",    {31'h0, mem_ren},    {31'h0, tv[i].e_ren});
         chk("mem_addr",   mem_addr,            tv[i].e_addr);
         chk("inst_valid", {31'h0, inst_valid}, {31'h0, tv[i].e_valid});
         if (i == 0 || (tv[i-1].rst && !tv[i].rst)) begin
            chk("post_reset_inst", inst,    32'h0000_0000);
            chk("post_reset_pc",   inst_pc, 32'h0000_0000);
         end
         // Scoreboard: decode consumes the head in this cycle.
         if (!tv[i].rst && !tv[i].redir && inst_valid && tv[i].ready) begin
            if (sbq.size() == 0) begin
               chk("unexpected_inst_pc", inst_pc, 32'hFFFF_FFFF);
            end else begin
               e = sbq.pop_front();
               chk("sb_inst_pc", inst_pc, e.pc);
               chk("sb_inst",    inst,    e.data);
            end
         end
         if (tv[i].rst || tv[i].redir) begin
            sbq.delete();
         end else if (tv[i].push) begin
            e.pc   = tv[i].e_addr;
            e.data = word_f(tv[i].e_addr);
            sbq.push_back(e);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
